// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token, data, then handshake, with bounded
// retry on NAK / CRC error / timeout and a single completion pulse.
module usb_txn_ctrl #(
    parameter int MAX_RETRY = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txn_start,
    input  logic       txn_is_in,
    input  logic       abort,
    output logic       txn_ready,
    output logic       txn_done,
    output logic       txn_success,
    output logic [3:0] txn_retries,
    output logic       dp_clear,
    output logic       send_token_start,
    output logic [3:0] send_token_pid,
    output logic       send_data_start,
    output logic       send_hand_start,
    output logic [3:0] send_hand_pid,
    input  logic       send_done,
    output logic       r_data_start,
    input  logic       r_data_success,
    input  logic       r_data_crc_err,
    input  logic       r_data_timeout,
    output logic       receive_hand,
    input  logic       r_ack,
    input  logic       r_nak,
    input  logic       r_acknak_fail
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOK_GO,
        S_TOK_WAIT,
        S_DIN_GO,
        S_DIN_WAIT,
        S_HS_GO,
        S_HS_WAIT,
        S_DOUT_GO,
        S_DOUT_WAIT,
        S_RHS_GO,
        S_RHS_WAIT,
        S_RETRY,
        S_DONE
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_t     state, state_n;
    logic       is_in, is_in_n;
    logic [3:0] retry_cnt, retry_n;
    logic       success_n;
    logic [3:0] retries_n;
    logic [3:0] tok_pid_n;
    logic [3:0] hand_pid_n;
    logic       finish;
    logic       finish_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            is_in          <= 1'b0;
            retry_cnt      <= 4'd0;
            txn_success    <= 1'b0;
            txn_retries    <= 4'd0;
            send_token_pid <= 4'd0;
            send_hand_pid  <= 4'd0;
        end else begin
            state          <= state_n;
            is_in          <= is_in_n;
            retry_cnt      <= retry_n;
            txn_success    <= success_n;
            txn_retries    <= retries_n;
            send_token_pid <= tok_pid_n;
            send_hand_pid  <= hand_pid_n;
        end
    end

    always_comb begin
        state_n    = state;
        is_in_n    = is_in;
        retry_n    = retry_cnt;
        success_n  = txn_success;
        retries_n  = txn_retries;
        tok_pid_n  = send_token_pid;
        hand_pid_n = send_hand_pid;
        finish     = 1'b0;
        finish_ok  = 1'b0;

        // abort outranks any response arriving in the same cycle
        if (abort && state != S_IDLE && state != S_DONE) begin
            finish = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (txn_start) begin
                        is_in_n   = txn_is_in;
                        retry_n   = 4'd0;
                        success_n = 1'b0;
                        retries_n = 4'd0;
                        tok_pid_n = txn_is_in ? PID_IN : PID_OUT;
                        state_n   = S_TOK_GO;
                    end
                end
                S_TOK_GO:   state_n = S_TOK_WAIT;
                S_TOK_WAIT: begin
                    if (send_done) state_n = is_in ? S_DIN_GO : S_DOUT_GO;
                end
                S_DIN_GO:   state_n = S_DIN_WAIT;
                S_DIN_WAIT: begin
                    if (r_data_timeout) begin
                        state_n = S_RETRY;
                    end else if (r_data_crc_err) begin
                        hand_pid_n = PID_NAK;
                        state_n    = S_HS_GO;
                    end else if (r_data_success) begin
                        hand_pid_n = PID_ACK;
                        state_n    = S_HS_GO;
                    end
                end
                S_HS_GO:    state_n = S_HS_WAIT;
                S_HS_WAIT: begin
                    if (send_done) begin
                        if (send_hand_pid == PID_ACK) begin
                            finish    = 1'b1;
                            finish_ok = 1'b1;
                        end else begin
                            state_n = S_RETRY;
                        end
                    end
                end
                S_DOUT_GO:   state_n = S_DOUT_WAIT;
                S_DOUT_WAIT: begin
                    if (send_done) state_n = S_RHS_GO;
                end
                S_RHS_GO:    state_n = S_RHS_WAIT;
                S_RHS_WAIT: begin
                    if (r_acknak_fail || r_nak) begin
                        state_n = S_RETRY;
                    end else if (r_ack) begin
                        finish    = 1'b1;
                        finish_ok = 1'b1;
                    end
                end
                S_RETRY: begin
                    // compared before increment, so the counter never exceeds MAX_RETRY
                    if (retry_cnt == RETRY_MAX) begin
                        finish = 1'b1;
                    end else begin
                        retry_n = retry_cnt + 4'd1;
                        state_n = S_TOK_GO;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        // status is published on entry to DONE so it is valid alongside txn_done
        if (finish) begin
            state_n   = S_DONE;
            success_n = finish_ok;
            retries_n = retry_cnt;
        end
    end

    assign txn_ready        = (state == S_IDLE);
    assign txn_done         = (state == S_DONE);
    assign dp_clear         = (state == S_TOK_GO);
    assign send_token_start = (state == S_TOK_GO);
    assign r_data_start     = (state == S_DIN_GO);
    assign send_hand_start  = (state == S_HS_GO);
    assign send_data_start  = (state == S_DOUT_GO);
    assign receive_hand     = (state == S_RHS_GO);

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboarded random/directed bench for usb_txn_ctrl: the driver plays the
// transmitter and receive FSMs, a monitor compares each completion against a model.
module tb_usb_txn_ctrl;

    localparam int MAX_RETRY = 8;

    localparam int SIG_TOK   = 0;
    localparam int SIG_RDATA = 1;
    localparam int SIG_HAND  = 2;
    localparam int SIG_DATA  = 3;
    localparam int SIG_RHAND = 4;
    localparam int SIG_DONE  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       txn_start, txn_is_in, abort;
    logic       txn_ready, txn_done, txn_success;
    logic [3:0] txn_retries;
    logic       dp_clear, send_token_start, send_data_start, send_hand_start;
    logic [3:0] send_token_pid, send_hand_pid;
    logic       send_done;
    logic       r_data_start, r_data_success, r_data_crc_err, r_data_timeout;
    logic       receive_hand, r_ack, r_nak, r_acknak_fail;

    usb_txn_ctrl #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .txn_start(txn_start), .txn_is_in(txn_is_in), .abort(abort),
        .txn_ready(txn_ready), .txn_done(txn_done), .txn_success(txn_success),
        .txn_retries(txn_retries), .dp_clear(dp_clear), .send_token_start(send_token_start),
        .send_token_pid(send_token_pid), .send_data_start(send_data_start),
        .send_hand_start(send_hand_start), .send_hand_pid(send_hand_pid), .send_done(send_done),
        .r_data_start(r_data_start), .r_data_success(r_data_success),
        .r_data_crc_err(r_data_crc_err), .r_data_timeout(r_data_timeout),
        .receive_hand(receive_hand), .r_ack(r_ack), .r_nak(r_nak), .r_acknak_fail(r_acknak_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_in;
        bit success;
        int retries;
        int tok;
        int data;
        int rdata;
        int rhand;
        int hack;
        int hnak;
    } exp_t;

    typedef int oc_t [16];

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int c_tok, c_clr, c_data, c_rdata, c_rhand, c_hack, c_hnak;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outcome codes per attempt. IN: 0 good data, 1 crc error, 2 timeout,
    // 3 crc+success together, 4 timeout+crc together. OUT: 0 ack, 1 nak,
    // 2 handshake timeout, 3 ack+nak together, 4 ack+timeout together.
    function automatic exp_t model(input bit is_in, input oc_t oc);
        exp_t e;
        e = '{default: 0};
        e.is_in = is_in;
        for (int k = 0; k <= MAX_RETRY; k++) begin
            e.tok++;
            e.retries = k;
            if (is_in) begin
                e.rdata++;
                if (oc[k] == 0) begin
                    e.hack++;
                    e.success = 1'b1;
                end else if (oc[k] == 1 || oc[k] == 3) begin
                    e.hnak++;
                end
            end else begin
                e.data++;
                e.rhand++;
                if (oc[k] == 0) e.success = 1'b1;
            end
            if (e.success) break;
        end
        return e;
    endfunction

    function automatic bit sig(input int sel);
        case (sel)
            SIG_TOK:   return send_token_start;
            SIG_RDATA: return r_data_start;
            SIG_HAND:  return send_hand_start;
            SIG_DATA:  return send_data_start;
            SIG_RHAND: return receive_hand;
            SIG_DONE:  return txn_done;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Looks at the current sample first, then up to limit further negedges.
    task automatic wait_sig(input int sel, input int limit, output int cyc);
        bit ok;
        ok  = sig(sel);
        cyc = 0;
        while (!ok && cyc < limit) begin
            @(negedge clk);
            cyc++;
            ok = sig(sel);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_pulse_%0d: not seen within %0d cycles, required 1 pulse", sel, limit);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "bench stalled waiting on DUT");
        end
    endtask

    task automatic clear_resp();
        r_data_success = 1'b0;
        r_data_crc_err = 1'b0;
        r_data_timeout = 1'b0;
        r_ack          = 1'b0;
        r_nak          = 1'b0;
        r_acknak_fail  = 1'b0;
    endtask

    task automatic drive_resp(input bit is_in, input int o);
        if (is_in) begin
            r_data_success = (o == 0 || o == 3);
            r_data_crc_err = (o == 1 || o == 3 || o == 4);
            r_data_timeout = (o == 2 || o == 4);
        end else begin
            r_ack         = (o == 0 || o == 3 || o == 4);
            r_nak         = (o == 1 || o == 3);
            r_acknak_fail = (o == 2 || o == 4);
        end
    endtask

    task automatic pulse_send_done(input int dly);
        wait_n(dly);
        send_done = 1'b1;
        wait_n(1);
        send_done = 1'b0;
    endtask

    task automatic run_txn(input bit is_in, input oc_t oc, input int d_tok, input int d_resp);
        exp_t e;
        int   cyc, dt, dr;
        bit   tok_seen, finished;
        e        = model(is_in, oc);
        tok_seen = 1'b0;
        finished = 1'b0;
        q.push_back(e);
        txn_is_in = is_in;
        txn_start = 1'b1;
        for (int k = 0; k <= MAX_RETRY && !finished; k++) begin
            dt = (d_tok != 0) ? d_tok : int'($urandom_range(2, 6));
            dr = (d_resp != 0) ? d_resp : int'($urandom_range(1, 6));
            if (!tok_seen) wait_sig(SIG_TOK, 40, cyc);
            tok_seen  = 1'b0;
            txn_start = 1'b0;
            wait_n(1);
            // stray responses and a stray start while only send_done matters
            if ($urandom_range(0, 3) == 0) begin
                r_data_success = 1'b1; r_data_crc_err = 1'b1; r_data_timeout = 1'b1;
                r_ack = 1'b1; r_nak = 1'b1; r_acknak_fail = 1'b1; txn_start = 1'b1;
            end
            wait_n(1);
            clear_resp();
            txn_start = 1'b0;
            pulse_send_done(dt - 2);
            if (is_in) begin
                wait_sig(SIG_RDATA, 10, cyc);
                wait_n(dr);
                drive_resp(1'b1, oc[k]);
                wait_n(1);
                clear_resp();
                if (oc[k] == 2 || oc[k] == 4) begin
                    if (k < MAX_RETRY) begin
                        wait_sig(SIG_TOK, 10, cyc);
                        chk("timeout_retry_to_token_cycles", cyc, 1);
                        tok_seen = 1'b1;
                    end
                end else begin
                    wait_sig(SIG_HAND, 10, cyc);
                    pulse_send_done(int'($urandom_range(1, 4)));
                    if (oc[k] == 0) finished = 1'b1;
                end
            end else begin
                wait_sig(SIG_DATA, 10, cyc);
                pulse_send_done(int'($urandom_range(1, 4)));
                wait_sig(SIG_RHAND, 10, cyc);
                wait_n(dr);
                drive_resp(1'b0, oc[k]);
                wait_n(1);
                clear_resp();
                if (oc[k] == 0) finished = 1'b1;
            end
        end
        wait_sig(SIG_DONE, 12, cyc);
        wait_n(1);
        chk("ready_after_done", txn_ready, 1);
        chk("success_hold", txn_success, e.success);
        chk("retries_hold", txn_retries, e.retries);
    endtask

    // Monitor: counts pulses per transaction and scores each completion.
    initial begin
        exp_t e;
        c_tok = 0; c_clr = 0; c_data = 0; c_rdata = 0; c_rhand = 0; c_hack = 0; c_hnak = 0;
        forever begin
            @(negedge clk);
            if (txn_ready === 1'b1) begin
                c_tok = 0; c_clr = 0; c_data = 0; c_rdata = 0; c_rhand = 0; c_hack = 0; c_hnak = 0;
            end
            if (send_token_start === 1'b1) begin
                c_tok++;
                if (q.size() > 0) chk("token_pid", send_token_pid, q[0].is_in ? 9 : 1);
            end
            if (dp_clear === 1'b1) c_clr++;
            if (send_data_start === 1'b1) c_data++;
            if (r_data_start === 1'b1) c_rdata++;
            if (receive_hand === 1'b1) c_rhand++;
            if (send_hand_start === 1'b1) begin
                if (send_hand_pid == 4'b0010) c_hack++;
                else if (send_hand_pid == 4'b1010) c_hnak++;
                else chk("hand_pid_legal", send_hand_pid, 2);
            end
            if (txn_done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got txn_done=1 expected no completion");
                end else begin
                    e = q.pop_front();
                    chk("done_success", txn_success, e.success);
                    chk("done_retries", txn_retries, e.retries);
                    chk("token_pulses", c_tok, e.tok);
                    chk("dp_clear_pulses", c_clr, e.tok);
                    chk("data_pulses", c_data, e.data);
                    chk("r_data_start_pulses", c_rdata, e.rdata);
                    chk("receive_hand_pulses", c_rhand, e.rhand);
                    chk("ack_hand_pulses", c_hack, e.hack);
                    chk("nak_hand_pulses", c_hnak, e.hnak);
                end
            end
        end
    end

    initial begin
        oc_t  oc;
        exp_t ea;
        int   cyc;
        bit   all_fail;
        rst = 1'b1; txn_start = 1'b0; txn_is_in = 1'b0; abort = 1'b0; send_done = 1'b0;
        clear_resp();
        wait_n(3);
        chk("rst_ready", txn_ready, 1);
        chk("rst_done", txn_done, 0);
        chk("rst_success", txn_success, 0);
        chk("rst_retries", txn_retries, 0);
        chk("rst_token_pid", send_token_pid, 0);
        chk("rst_hand_pid", send_hand_pid, 0);
        chk("rst_token_start", send_token_start, 0);
        chk("rst_dp_clear", dp_clear, 0);
        rst = 1'b0;
        wait_n(2);

        // clean IN with the fixed latencies
        oc = '{default: 0};
        run_txn(1'b1, oc, 5, 20);
        // IN: two CRC errors then good data
        oc = '{default: 0}; oc[0] = 1; oc[1] = 1;
        run_txn(1'b1, oc, 0, 0);
        // OUT: NAK on every attempt
        oc = '{default: 1};
        run_txn(1'b0, oc, 0, 0);
        // OUT: handshake timeout, ack+nak together, then ack
        oc = '{default: 0}; oc[0] = 2; oc[1] = 3;
        run_txn(1'b0, oc, 0, 0);
        // IN: data timeout on the first attempt
        oc = '{default: 0}; oc[0] = 2;
        run_txn(1'b1, oc, 0, 0);

        // reset while waiting for the OUT data packet to finish
        txn_is_in = 1'b0;
        txn_start = 1'b1;
        wait_sig(SIG_TOK, 10, cyc);
        txn_start = 1'b0;
        pulse_send_done(1);
        wait_sig(SIG_DATA, 10, cyc);
        wait_n(1);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        chk("rst_mid_ready", txn_ready, 1);
        chk("rst_mid_done", txn_done, 0);
        chk("rst_mid_token_pid", send_token_pid, 0);
        for (int i = 0; i < 4; i++) begin
            wait_n(1);
            chk("rst_mid_no_done", txn_done, 0);
        end

        // abort in TOK_WAIT with send_done in the same cycle
        ea = '{default: 0};
        ea.tok = 1;
        q.push_back(ea);
        txn_is_in = 1'b0;
        txn_start = 1'b1;
        wait_sig(SIG_TOK, 10, cyc);
        txn_start = 1'b0;
        wait_n(1);
        abort = 1'b1;
        send_done = 1'b1;
        wait_n(1);
        abort = 1'b0;
        send_done = 1'b0;
        chk("abort_done", txn_done, 1);
        chk("abort_success", txn_success, 0);
        chk("abort_no_data", send_data_start, 0);
        wait_n(1);
        chk("abort_ready", txn_ready, 1);
        chk("abort_no_data_after", send_data_start, 0);
        wait_n(2);

        for (int t = 0; t < 40; t++) begin
            all_fail = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 16; k++) begin
                if (all_fail || $urandom_range(0, 2) != 0) oc[k] = int'($urandom_range(1, 4));
                else oc[k] = 0;
            end
            run_txn(1'($urandom_range(0, 1)), oc, 0, 0);
            wait_n(int'($urandom_range(0, 3)));
        end

        wait_n(5);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
